button_sequence_checker: RTL and testbench
==========================================

Name: button_sequence_checker

Overview:
- Downstream consumer of the 4-bit random button generator.
- On start, it captures SEQ_LEN random button codes into a buffer and presents them one at a time to the display/LED logic.
- It then checks the player's debounced button presses against the stored sequence and reports pass or strike to the bomb top-level.
- This block implements one "memory" phase of the bomb.

Parameters:
- SEQ_LEN, 4, number of codes per sequence (legal range 1..8).
- SHOW_CYCLES, 25000000, cycles each code is displayed; the same count is used for the blank gap after it.
- TIMEOUT_CYCLES, 250000000, maximum idle cycles allowed between presses in the input phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a new sequence.
- rand_code  in  4  button code from the random generator, valid every cycle, range 0..11.
- btn_valid  in  1  single-cycle pulse for one debounced press.
- btn_code  in  4  code of the pressed button, same encoding as rand_code.
- show_valid  out  1  high while show_code is to be displayed.
- show_code  out  4  code currently displayed.
- show_idx  out  3  index of the displayed code.
- busy  out  1  high in LOAD, SHOW and WAIT_IN.
- progress  out  4  number of correct presses so far in the current attempt.
- pass  out  1  one-cycle pulse when the whole sequence is entered correctly.
- strike  out  1  one-cycle pulse on a wrong press or a timeout.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Buffer cleared to 0; idx = 0; timer = 0.
- FSM states: IDLE, LOAD, SHOW_ON, SHOW_OFF, WAIT_IN, DONE.
- IDLE/DONE:
  - start=1 at a clock edge moves to LOAD on the next cycle, with idx=0 and progress=0.
  - In DONE, progress holds at SEQ_LEN until start.
- LOAD:
  - Lasts exactly SEQ_LEN cycles; in the k-th cycle, seq[k] is written from rand_code.
  - Any rand_code of 12..15 is stored as 11 (defensive clamp).
  - After the last write, go to SHOW_ON with idx=0.
- SHOW_ON:
  - show_valid=1, show_code=seq[idx], show_idx=idx, all registered.
  - Lasts SHOW_CYCLES cycles, then SHOW_OFF.
- SHOW_OFF:
  - show_valid=0; show_code and show_idx hold their last values.
  - Lasts SHOW_CYCLES cycles.
  - Then, if idx==SEQ_LEN-1, go to WAIT_IN with idx=0, progress=0 and the timer loaded; otherwise idx+1 and back to SHOW_ON.
- WAIT_IN, on btn_valid:
  - btn_code==seq[idx] and idx<SEQ_LEN-1: idx+1, progress+1, timer reloaded.
  - btn_code==seq[idx] and idx==SEQ_LEN-1: progress=SEQ_LEN, pass pulse next cycle, go to DONE.
  - Mismatch: strike pulse, progress=0, idx=0, go to SHOW_ON (the same sequence is replayed, not regenerated).
- WAIT_IN, no btn_valid: the timer decrements. On expiry after TIMEOUT_CYCLES cycles without a press: strike pulse, idx=0, progress=0, go to SHOW_ON.
- Simultaneous events:
  - btn_valid in the same cycle as timer expiry: the press is evaluated and the timeout is ignored.
  - start outside IDLE/DONE is ignored.
  - btn_valid outside WAIT_IN is ignored and does not affect progress.
- pass and strike are never asserted in the same cycle. Each is exactly one cycle wide.
- Reset mid-operation: immediate return to IDLE; pass/strike drop asynchronously; the buffer is cleared.
- Widths:
  - Timer is wide enough for max(SHOW_CYCLES, TIMEOUT_CYCLES).
  - idx is 3 bits; progress is 4 bits (range 0..8).

Decomposition:
- Shared package bomb_pkg:
  - Button code localparams: UP1=0, DOWN1=1, RIGHT1=2, LEFT1=3, A1=4, B1=5, UP2=6, DOWN2=7, RIGHT2=8, LEFT2=9, A2=10, B2=11.
  - NUM_BUTTONS=12.
  - The state enum typedef for this FSM.
- One sub-module, phase_timer: a loadable down-counter with load value, enable and a one-cycle expire pulse. It is shared by the SHOW and WAIT_IN timing.

Test Plan (bench parameters: SEQ_LEN=3, SHOW_CYCLES=4, TIMEOUT_CYCLES=20):
1. Load and show: start, rand_code driven 5, 2, 9 on the three LOAD cycles -> show_valid high 4 cycles with show_code 5, idx 0, then low 4 cycles; then 2, idx 1; then 9, idx 2; then WAIT_IN with busy=1.
2. Correct entry: press 5, 2, 9 -> progress 1, 2, 3; pass pulses for exactly 1 cycle; state DONE; busy=0; strike never asserted.
3. Wrong press: press 5, then 7 -> strike for 1 cycle, progress=0, replay shows 5, 2, 9 again; the buffer is unchanged.
4. Timeout and tie-break:
   - No press for 20 cycles in WAIT_IN -> strike for 1 cycle, replay begins.
   - A correct press on the expiry cycle -> no strike, progress+1.
5. Ignored inputs and clamp:
   - btn_valid during SHOW_ON/SHOW_OFF and start during WAIT_IN -> no state change.
   - rand_code=14 during LOAD -> stored and shown as 11.
6. Async reset: assert rst mid-WAIT_IN between clock edges -> all outputs 0 immediately; after release, start and new codes 0, 11, 6 are shown correctly.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb project.
// Contents:
//   - button code constants used by the random generator and the button decoder
//   - the state type of the memory-phase sequence checker
//   - clamp_code: forces any out-of-range code to the highest legal button
package bomb_pkg;

  localparam logic [3:0] UP1    = 4'd0;
  localparam logic [3:0] DOWN1  = 4'd1;
  localparam logic [3:0] RIGHT1 = 4'd2;
  localparam logic [3:0] LEFT1  = 4'd3;
  localparam logic [3:0] A1     = 4'd4;
  localparam logic [3:0] B1     = 4'd5;
  localparam logic [3:0] UP2    = 4'd6;
  localparam logic [3:0] DOWN2  = 4'd7;
  localparam logic [3:0] RIGHT2 = 4'd8;
  localparam logic [3:0] LEFT2  = 4'd9;
  localparam logic [3:0] A2     = 4'd10;
  localparam logic [3:0] B2     = 4'd11;

  localparam int NUM_BUTTONS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_DONE
  } seq_state_t;

  // Codes 12..15 cannot come from a real button, so they collapse onto B2.
  function automatic logic [3:0] clamp_code(input logic [3:0] code);
    return (code > B2) ? B2 : code;
  endfunction

endpackage

// File: rtl/button_sequence_checker_if.sv
// Signal bundle between the bomb top-level and the memory-phase checker.
// Ports (as seen from the checker, modport slave):
//   start      in   begin a new sequence (single-cycle)
//   rand_code  in   code from the random button generator
//   btn_valid  in   one debounced press
//   btn_code   in   code of the pressed button
//   show_valid out  show_code is to be displayed
//   show_code  out  code currently displayed
//   show_idx   out  position of the displayed code
//   busy       out  phase in progress
//   progress   out  correct presses so far
//   pass       out  sequence completed (one-cycle pulse)
//   strike     out  wrong press or timeout (one-cycle pulse)
interface button_sequence_checker_if;

  logic       start;
  logic [3:0] rand_code;
  logic       btn_valid;
  logic [3:0] btn_code;
  logic       show_valid;
  logic [3:0] show_code;
  logic [2:0] show_idx;
  logic       busy;
  logic [3:0] progress;
  logic       pass;
  logic       strike;

  modport master (
    output start, rand_code, btn_valid, btn_code,
    input  show_valid, show_code, show_idx, busy, progress, pass, strike
  );

  modport slave (
    input  start, rand_code, btn_valid, btn_code,
    output show_valid, show_code, show_idx, busy, progress, pass, strike
  );

endinterface

// File: rtl/button_sequence_checker_phase_timer.sv
// Loadable down-counter used for both the display timing and the input timeout.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   load        load load_value into the counter (takes priority)
//   load_value  value loaded; the phase then lasts load_value+1 enabled cycles
//   enable      count down while high
//   expire      high for the one enabled cycle in which the count is zero
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // The owner reloads on expiry, so this stays a single-cycle pulse.
  assign expire = enable && (count == '0);

endmodule

// File: rtl/button_sequence_checker.sv
// Memory phase of the bomb: captures SEQ_LEN random codes, shows them one at
// a time, then checks the player's presses against them.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       button_sequence_checker_if.slave (see interface for signals)
module button_sequence_checker
  import bomb_pkg::*;
#(
  parameter int SEQ_LEN        = 4,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input logic                      clk,
  input logic                      rst,
  button_sequence_checker_if.slave bus
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(SEQ_LEN - 1);
  localparam logic [3:0]    FULL      = 4'(SEQ_LEN);

  seq_state_t state, state_next;

  // Always eight entries so a 3-bit index never addresses past the array.
  logic [3:0] seq [8];
  logic [2:0] idx, idx_next;
  logic [3:0] progress, progress_next;
  logic       show_valid, show_valid_next;
  logic [3:0] show_code, show_code_next;
  logic [2:0] show_idx, show_idx_next;
  logic       pass, pass_next;
  logic       strike, strike_next;
  logic       seq_we;
  logic       show_start;
  logic [3:0] load_code;
  logic       timer_load, timer_en, timer_expire;
  logic [TW-1:0] timer_value;

  assign load_code = clamp_code(bus.rand_code);
  assign timer_en  = (state == ST_SHOW_ON) || (state == ST_SHOW_OFF) || (state == ST_WAIT_IN);

  phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .expire     (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // show_start gathers every path into SHOW_ON (end of LOAD, next code,
  // strike replay) so the display registers and timer are set in one place.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    progress_next   = progress;
    show_valid_next = show_valid;
    show_code_next  = show_code;
    show_idx_next   = show_idx;
    pass_next       = 1'b0;
    strike_next     = 1'b0;
    seq_we          = 1'b0;
    show_start      = 1'b0;
    timer_load      = 1'b0;
    timer_value     = SHOW_LOAD;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next    = ST_LOAD;
          idx_next      = 3'd0;
          progress_next = 4'd0;
        end
      end
      ST_LOAD: begin
        seq_we = 1'b1;
        if (idx == LAST_IDX) begin
          idx_next   = 3'd0;
          show_start = 1'b1;
        end else begin
          idx_next = idx + 3'd1;
        end
      end
      ST_SHOW_ON: begin
        if (timer_expire) begin
          state_next      = ST_SHOW_OFF;
          show_valid_next = 1'b0;
          timer_load      = 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (timer_expire) begin
          if (idx == LAST_IDX) begin
            state_next    = ST_WAIT_IN;
            idx_next      = 3'd0;
            progress_next = 4'd0;
            timer_load    = 1'b1;
            timer_value   = WAIT_LOAD;
          end else begin
            idx_next   = idx + 3'd1;
            show_start = 1'b1;
          end
        end
      end
      ST_WAIT_IN: begin
        // A press wins over a timeout landing in the same cycle.
        if (bus.btn_valid) begin
          if (bus.btn_code == seq[idx]) begin
            if (idx == LAST_IDX) begin
              state_next    = ST_DONE;
              progress_next = FULL;
              pass_next     = 1'b1;
            end else begin
              idx_next      = idx + 3'd1;
              progress_next = progress + 4'd1;
              timer_load    = 1'b1;
              timer_value   = WAIT_LOAD;
            end
          end else begin
            strike_next   = 1'b1;
            idx_next      = 3'd0;
            progress_next = 4'd0;
            show_start    = 1'b1;
          end
        end else if (timer_expire) begin
          strike_next   = 1'b1;
          idx_next      = 3'd0;
          progress_next = 4'd0;
          show_start    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (show_start) begin
      state_next      = ST_SHOW_ON;
      show_valid_next = 1'b1;
      show_idx_next   = idx_next;
      // Bypass covers SEQ_LEN==1, where entry 0 is written on this same edge.
      show_code_next  = (seq_we && (idx == idx_next)) ? load_code : seq[idx_next];
      timer_load      = 1'b1;
      timer_value     = SHOW_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) seq[i] <= '0;
      idx        <= '0;
      progress   <= '0;
      show_valid <= 1'b0;
      show_code  <= '0;
      show_idx   <= '0;
      pass       <= 1'b0;
      strike     <= 1'b0;
    end else begin
      if (seq_we) seq[idx] <= load_code;
      idx        <= idx_next;
      progress   <= progress_next;
      show_valid <= show_valid_next;
      show_code  <= show_code_next;
      show_idx   <= show_idx_next;
      pass       <= pass_next;
      strike     <= strike_next;
    end
  end

  assign bus.show_valid = show_valid;
  assign bus.show_code  = show_code;
  assign bus.show_idx   = show_idx;
  assign bus.busy       = (state == ST_LOAD) || (state == ST_SHOW_ON) ||
                          (state == ST_SHOW_OFF) || (state == ST_WAIT_IN);
  assign bus.progress   = progress;
  assign bus.pass       = pass;
  assign bus.strike     = strike;

endmodule

// File: tb/tb_button_sequence_checker.sv
// Self-checking bench for button_sequence_checker with SEQ_LEN=3,
// SHOW_CYCLES=4, TIMEOUT_CYCLES=20. Each cycle drives inputs, queues the
// outputs expected after the next rising edge, and compares 1ns after it.
module tb_button_sequence_checker;
  import bomb_pkg::*;

  localparam int SEQ_LEN        = 3;
  localparam int SHOW_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 20;

  typedef struct packed {
    logic       show_valid;
    logic [3:0] show_code;
    logic [2:0] show_idx;
    logic       busy;
    logic [3:0] progress;
    logic       pass;
    logic       strike;
  } out_t;

  typedef struct {
    logic       start;
    logic [3:0] rand_code;
    logic       btn_valid;
    logic [3:0] btn_code;
    out_t       exp_out;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp_out;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_sequence_checker_if bus();

  button_sequence_checker #(
    .SEQ_LEN        (SEQ_LEN),
    .SHOW_CYCLES    (SHOW_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  sb_t  sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  out_t cur;

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic checkOutput();
    sb_t  e;
    out_t a;
    a.show_valid = bus.show_valid;
    a.show_code  = bus.show_code;
    a.show_idx   = bus.show_idx;
    a.busy       = bus.busy;
    a.progress   = bus.progress;
    a.pass       = bus.pass;
    a.strike     = bus.strike;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got an output with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    if (a !== e.exp_out) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%0b code=%0d idx=%0d busy=%0b prog=%0d pass=%0b strike=%0b, expected valid=%0b code=%0d idx=%0d busy=%0b prog=%0d pass=%0b strike=%0b",
               e.name, a.show_valid, a.show_code, a.show_idx, a.busy, a.progress, a.pass, a.strike,
               e.exp_out.show_valid, e.exp_out.show_code, e.exp_out.show_idx, e.exp_out.busy,
               e.exp_out.progress, e.exp_out.pass, e.exp_out.strike);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    sb_t s;
    bus.start     = v.start;
    bus.rand_code = v.rand_code;
    bus.btn_valid = v.btn_valid;
    bus.btn_code  = v.btn_code;
    s.name    = name;
    s.exp_out = v.exp_out;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runCycle(input string name, input logic st, input logic [3:0] rc,
                          input logic bv, input logic [3:0] bc);
    vec_t v;
    v.start     = st;
    v.rand_code = rc;
    v.btn_valid = bv;
    v.btn_code  = bc;
    v.exp_out   = cur;
    applyStimulus(name, v);
  endtask

  // Starts from the edge that entered SHOW_ON with code 0 visible; ends on
  // the edge that enters WAIT_IN. Optional noise presses must be ignored.
  task automatic showPhase(input string name, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input bit noise);
    logic [3:0] c [3];
    c[0] = c0;
    c[1] = c1;
    c[2] = c2;
    cur.strike   = 1'b0;
    cur.busy     = 1'b1;
    cur.progress = 4'd0;
    for (int k = 0; k < 3; k++) begin
      cur.show_valid = 1'b1;
      cur.show_code  = c[k];
      cur.show_idx   = 3'(k);
      for (int i = 0; i < SHOW_CYCLES - 1; i++)
        runCycle({name, "_on"}, 1'b0, 4'd0, noise, 4'($urandom_range(0, 11)));
      cur.show_valid = 1'b0;
      for (int i = 0; i < SHOW_CYCLES; i++)
        runCycle({name, "_off"}, 1'b0, 4'd0, noise, 4'($urandom_range(0, 11)));
      if (k < 2) begin
        cur.show_valid = 1'b1;
        cur.show_code  = c[k+1];
        cur.show_idx   = 3'(k + 1);
      end
      runCycle({name, "_next"}, 1'b0, 4'd0, 1'b0, 4'd0);
    end
  endtask

  task automatic startLoad(input string name, input logic [3:0] r0, input logic [3:0] r1,
                           input logic [3:0] r2, input logic [3:0] shown0);
    cur.busy       = 1'b1;
    cur.progress   = 4'd0;
    cur.show_valid = 1'b0;
    cur.pass       = 1'b0;
    cur.strike     = 1'b0;
    runCycle({name, "_start"}, 1'b1, 4'd0, 1'b0, 4'd0);
    runCycle({name, "_load0"}, 1'b0, r0, 1'b0, 4'd0);
    runCycle({name, "_load1"}, 1'b0, r1, 1'b0, 4'd0);
    cur.show_valid = 1'b1;
    cur.show_code  = shown0;
    cur.show_idx   = 3'd0;
    runCycle({name, "_load2"}, 1'b0, r2, 1'b0, 4'd0);
  endtask

  task automatic idleCycles(input string name, input int n);
    for (int i = 0; i < n; i++) runCycle(name, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic press(input string name, input logic [3:0] code);
    runCycle(name, 1'b0, 4'd0, 1'b1, code);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, test did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[4];
    sb_t  s;

    bus.start     = 1'b0;
    bus.rand_code = 4'd0;
    bus.btn_valid = 1'b0;
    bus.btn_code  = 4'd0;
    cur = '0;

    #1;
    s.name = "reset_state"; s.exp_out = cur; sb_q.push_back(s);
    checkOutput();
    @(posedge clk);
    #1;
    s.name = "reset_hold"; s.exp_out = cur; sb_q.push_back(s);
    checkOutput();
    rst = 1'b0;

    // Start and LOAD of 5, 2, 9.
    tbl[0] = '{start: 1'b1, rand_code: 4'd0, btn_valid: 1'b0, btn_code: 4'd0,
               exp_out: '{show_valid: 1'b0, show_code: 4'd0, show_idx: 3'd0, busy: 1'b1,
                          progress: 4'd0, pass: 1'b0, strike: 1'b0}};
    tbl[1] = '{start: 1'b0, rand_code: 4'd5, btn_valid: 1'b0, btn_code: 4'd0,
               exp_out: '{show_valid: 1'b0, show_code: 4'd0, show_idx: 3'd0, busy: 1'b1,
                          progress: 4'd0, pass: 1'b0, strike: 1'b0}};
    tbl[2] = '{start: 1'b0, rand_code: 4'd2, btn_valid: 1'b0, btn_code: 4'd0,
               exp_out: '{show_valid: 1'b0, show_code: 4'd0, show_idx: 3'd0, busy: 1'b1,
                          progress: 4'd0, pass: 1'b0, strike: 1'b0}};
    tbl[3] = '{start: 1'b0, rand_code: 4'd9, btn_valid: 1'b0, btn_code: 4'd0,
               exp_out: '{show_valid: 1'b1, show_code: 4'd5, show_idx: 3'd0, busy: 1'b1,
                          progress: 4'd0, pass: 1'b0, strike: 1'b0}};
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("load_tbl%0d", i), tbl[i]);
    cur = tbl[3].exp_out;

    showPhase("show1", 4'd5, 4'd2, 4'd9, 1'b0);

    // Wrong second press: strike and replay of the same buffer.
    cur.progress = 4'd1;
    press("press_ok_5", 4'd5);
    cur.progress = 4'd0; cur.strike = 1'b1;
    cur.show_valid = 1'b1; cur.show_code = 4'd5; cur.show_idx = 3'd0;
    press("press_wrong_7", 4'd7);
    showPhase("replay_wrong", 4'd5, 4'd2, 4'd9, 1'b0);

    // Timeout after TIMEOUT_CYCLES idle cycles.
    idleCycles("wait_idle", TIMEOUT_CYCLES - 1);
    cur.strike = 1'b1;
    cur.show_valid = 1'b1; cur.show_code = 4'd5; cur.show_idx = 3'd0;
    idleCycles("timeout_strike", 1);
    showPhase("replay_timeout", 4'd5, 4'd2, 4'd9, 1'b0);

    // Correct press on the expiry cycle beats the timeout.
    cur.progress = 4'd1;
    press("tie_first", 4'd5);
    idleCycles("tie_idle", TIMEOUT_CYCLES - 1);
    cur.progress = 4'd2;
    press("tie_press_on_expiry", 4'd2);
    cur.progress = 4'd3; cur.pass = 1'b1; cur.busy = 1'b0;
    press("pass_pulse", 4'd9);
    cur.pass = 1'b0;
    idleCycles("pass_width", 1);
    press("done_btn_ignored", 4'd5);

    // Clamp of 14 to 11, noise presses during the display, start in WAIT_IN.
    startLoad("load_clamp", 4'd14, 4'd3, 4'd1, 4'd11);
    showPhase("show_clamp", 4'd11, 4'd3, 4'd1, 1'b1);
    runCycle("wait_start_ignored", 1'b1, 4'd0, 1'b0, 4'd0);
    cur.progress = 4'd1;
    press("press_clamped_11", 4'd11);
    cur.progress = 4'd2;
    press("press_clamp_3", 4'd3);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    cur = '0;
    s.name = "async_reset"; s.exp_out = cur; sb_q.push_back(s);
    checkOutput();
    @(posedge clk);
    #1;
    s.name = "async_reset_hold"; s.exp_out = cur; sb_q.push_back(s);
    checkOutput();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    startLoad("load_after_reset", 4'd0, 4'd11, 4'd6, 4'd0);
    showPhase("show_after_reset", 4'd0, 4'd11, 4'd6, 1'b0);
    cur.progress = 4'd1;
    press("after_reset_p0", 4'd0);
    cur.progress = 4'd2;
    press("after_reset_p11", 4'd11);
    cur.progress = 4'd3; cur.pass = 1'b1; cur.busy = 1'b0;
    press("after_reset_pass", 4'd6);
    cur.pass = 1'b0;
    idleCycles("after_reset_done", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
